// File: rtl/data_mem_responder.sv
// Data-memory slave for the RV32I load/store port: one outstanding request,
// byte-lane stores, sign/zero-extended loads, programmable wait states.
module data_mem_responder #(
   parameter int XLEN        = 32,
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] mem_addr,
   input  logic [XLEN-1:0] mem_out,
   input  logic [1:0]      mem_ctrl,
   input  logic [2:0]      mem_funct3,
   output logic            req_ready,
   output logic [XLEN-1:0] mem_in,
   output logic            resp_valid,
   output logic            resp_err
);

   localparam int ADDR_LEN = $clog2(DEPTH_WORDS);
   localparam logic [ADDR_LEN:0] DEPTH_L  = (ADDR_LEN+1)'(DEPTH_WORDS);
   localparam logic [3:0]        CNT_INIT = 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);
   localparam bit                NO_WAIT  = (WAIT_CYCLES == 0);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

   state_e            state_q;
   logic [3:0]        cnt_q;
   logic [XLEN-1:0]   addr_q;
   logic [XLEN-1:0]   wdata_q;
   logic [1:0]        ctrl_q;
   logic [2:0]        f3_q;
   logic [XLEN-1:0]   mem_in_q;
   logic              resp_valid_q;
   logic              resp_err_q;

   logic [XLEN-1:0]   mem_q [DEPTH_WORDS];

   logic              in_idle;
   logic [XLEN-1:0]   src_addr;
   logic [XLEN-1:0]   src_wdata;
   logic [1:0]        src_ctrl;
   logic [2:0]        src_f3;
   logic [ADDR_LEN-1:0] idx;
   logic [XLEN-1:0]   rd_word;
   logic [XLEN-1:0]   lane_word;
   logic [7:0]        byte_v;
   logic [15:0]       half_v;
   logic              is_load;
   logic              is_store;
   logic              f3_ok;
   logic              misalign;
   logic              range_err;
   logic              err_d;
   logic              enter_resp;
   logic              we_d;
   logic [XLEN-1:0]   rdata_d;
   logic [XLEN-1:0]   wr_word_d;

   // With no wait states the accept edge is also the edge entering RESP, so
   // the access is decoded straight from the bus while idle.
   assign in_idle   = (state_q == S_IDLE);
   assign src_addr  = in_idle ? mem_addr   : addr_q;
   assign src_wdata = in_idle ? mem_out    : wdata_q;
   assign src_ctrl  = in_idle ? mem_ctrl   : ctrl_q;
   assign src_f3    = in_idle ? mem_funct3 : f3_q;

   assign idx       = src_addr[ADDR_LEN+1:2];
   assign rd_word   = mem_q[idx];
   assign lane_word = rd_word >> {src_addr[1:0], 3'b000};
   assign byte_v    = lane_word[7:0];
   assign half_v    = src_addr[1] ? rd_word[31:16] : rd_word[15:0];

   assign enter_resp = (in_idle && (mem_ctrl != 2'b00) && NO_WAIT) ||
                       ((state_q == S_WAIT) && (cnt_q == 4'd0));

   always_comb begin
      is_load   = (src_ctrl == 2'b01);
      is_store  = (src_ctrl == 2'b10);
      f3_ok     = 1'b0;
      if (is_load)
         f3_ok = src_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      else if (is_store)
         f3_ok = src_f3 inside {3'b000, 3'b001, 3'b010};
      misalign  = ((src_f3[1:0] == 2'b01) && src_addr[0]) ||
                  ((src_f3[1:0] == 2'b10) && (src_addr[1:0] != 2'b00));
      range_err = ((src_addr >> (ADDR_LEN + 2)) != '0) || ({1'b0, idx} >= DEPTH_L);
      err_d     = !f3_ok || misalign || range_err;

      rdata_d = '0;
      if (is_load && !err_d) begin
         unique case (src_f3[1:0])
            2'b00:   rdata_d = {{(XLEN-8){byte_v[7] & ~src_f3[2]}}, byte_v};
            2'b01:   rdata_d = {{(XLEN-16){half_v[15] & ~src_f3[2]}}, half_v};
            default: rdata_d = rd_word;
         endcase
      end

      wr_word_d = rd_word;
      unique case (src_f3[1:0])
         2'b00:   wr_word_d[{src_addr[1:0], 3'b000} +: 8] = src_wdata[7:0];
         2'b01:   wr_word_d[{src_addr[1], 4'b0000} +: 16] = src_wdata[15:0];
         default: wr_word_d = src_wdata;
      endcase
      we_d = enter_resp && is_store && !err_d && !rst;
   end

   always_ff @(posedge clk) begin
      if (we_d)
         mem_q[idx] <= wr_word_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         ctrl_q       <= '0;
         f3_q         <= '0;
         mem_in_q     <= '0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (mem_ctrl != 2'b00) begin
                  addr_q  <= mem_addr;
                  wdata_q <= mem_out;
                  ctrl_q  <= mem_ctrl;
                  f3_q    <= mem_funct3;
                  if (NO_WAIT) begin
                     state_q      <= S_RESP;
                     resp_valid_q <= 1'b1;
                     resp_err_q   <= err_d;
                     mem_in_q     <= rdata_d;
                  end else begin
                     state_q <= S_WAIT;
                     cnt_q   <= CNT_INIT;
                  end
               end
            end
            S_WAIT: begin
               if (cnt_q == 4'd0) begin
                  state_q      <= S_RESP;
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= err_d;
                  mem_in_q     <= rdata_d;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            default: begin
               state_q      <= S_IDLE;
               resp_valid_q <= 1'b0;
               resp_err_q   <= 1'b0;
               mem_in_q     <= '0;
            end
         endcase
      end
   end

   assign req_ready  = in_idle;
   assign mem_in     = mem_in_q;
   assign resp_valid = resp_valid_q;
   assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: three responders (0, 2 and 3 wait states) driven against a
// byte-array reference model; a negedge monitor checks every response and req_ready.
module tb_data_mem_responder;

   localparam int DEPTH = 1024;

   typedef struct packed {
      logic [31:0] cyc;
      logic        err;
      logic        chk;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic [2:0]  rst_s;
   logic [31:0] addr_s  [3];
   logic [31:0] data_s  [3];
   logic [1:0]  ctrl_s  [3];
   logic [2:0]  f3_s    [3];
   logic [2:0]  ready_s;
   logic [31:0] mem_in_s [3];
   logic [2:0]  valid_s;
   logic [2:0]  err_s;

   int          cyc = 0;
   int          busy_until [3] = '{-1, -1, -1};
   int          checks = 0;
   int          errors = 0;
   exp_t        q [3][$];
   logic [7:0]  mdl [3][4096];
   exp_t        mon_e;
   logic        mon_rdy;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      data_mem_responder #(
         .XLEN        (32),
         .DEPTH_WORDS (DEPTH),
         .WAIT_CYCLES (g == 0 ? 0 : g + 1)
      ) u_dut (
         .clk        (clk),
         .rst        (rst_s[g]),
         .mem_addr   (addr_s[g]),
         .mem_out    (data_s[g]),
         .mem_ctrl   (ctrl_s[g]),
         .mem_funct3 (f3_s[g]),
         .req_ready  (ready_s[g]),
         .mem_in     (mem_in_s[g]),
         .resp_valid (valid_s[g]),
         .resp_err   (err_s[g])
      );
   end

   function automatic int wait_of(input int i);
      return (i == 0) ? 0 : i + 1;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp_v, cyc);
      end
   endtask

   // Reference: memory is a flat byte array; accesses are little-endian byte runs.
   function automatic void model(input int i, input logic [1:0] c, input logic [2:0] f,
                                 input logic [31:0] a, input logic [31:0] d,
                                 output logic er, output logic [31:0] rd);
      int sz;
      sz = (f[1:0] == 2'b00) ? 1 : (f[1:0] == 2'b01) ? 2 : 4;
      er = 1'b0;
      rd = '0;
      if (c == 2'b11) er = 1'b1;
      else if (c == 2'b01 && !(f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) er = 1'b1;
      else if (c == 2'b10 && f > 3'd2) er = 1'b1;
      if (!er && (a % 32'(sz)) != 0) er = 1'b1;
      if (!er && a >= 32'(4 * DEPTH)) er = 1'b1;
      if (!er) begin
         for (int k = 0; k < sz; k++) begin
            if (c == 2'b10) mdl[i][a + 32'(k)] = d[8*k +: 8];
            else            rd[8*k +: 8] = mdl[i][a + 32'(k)];
         end
         if (c == 2'b01 && !f[2] && sz < 4 && rd[8*sz-1])
            rd = rd | ~((32'h1 << (8*sz)) - 32'h1);
      end
   endfunction

   task automatic issue(input int i, input logic [1:0] c, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] d, input bit scr);
      exp_t e;
      logic er;
      logic [31:0] rd;
      @(negedge clk); #1;
      while (cyc <= busy_until[i]) begin
         if (scr) begin
            ctrl_s[i] = 2'($urandom_range(1, 3));
            f3_s[i]   = 3'($urandom);
            addr_s[i] = $urandom;
            data_s[i] = $urandom;
         end
         @(negedge clk); #1;
      end
      ctrl_s[i] = c;
      f3_s[i]   = f;
      addr_s[i] = a;
      data_s[i] = d;
      model(i, c, f, a, d, er, rd);
      e.cyc  = 32'(cyc + 1 + wait_of(i));
      e.err  = er;
      e.chk  = (c == 2'b01) || er;
      e.data = rd;
      q[i].push_back(e);
      busy_until[i] = cyc + 1 + wait_of(i);
   endtask

   task automatic quiesce(input int i);
      @(negedge clk); #1;
      while (cyc <= busy_until[i]) begin
         @(negedge clk); #1;
      end
      ctrl_s[i] = 2'b00;
   endtask

   task automatic rand_op(input int i, input bit scr);
      logic [1:0]  c;
      logic [2:0]  f;
      logic [31:0] a;
      logic [2:0]  lds [5];
      int r, sz;
      lds = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      r = int'($urandom_range(0, 99));
      c = (r < 45) ? 2'b01 : (r < 90) ? 2'b10 : 2'b11;
      if ($urandom_range(0, 9) == 0) f = 3'($urandom);
      else if (c == 2'b01)           f = lds[$urandom_range(0, 4)];
      else                           f = 3'($urandom_range(0, 2));
      sz = (f[1:0] == 2'b00) ? 1 : (f[1:0] == 2'b01) ? 2 : 4;
      r = int'($urandom_range(0, 99));
      if (r < 80)      a = 32'($urandom_range(0, 63));
      else if (r < 90) a = 32'hFFC + 32'($urandom_range(0, 3));
      else if (r < 95) a = 32'h1000 + 32'($urandom_range(0, 255));
      else             a = 32'h1 << $urandom_range(12, 31);
      if ($urandom_range(0, 9) < 7 && sz > 1) a = a & ~32'(sz - 1);
      issue(i, c, f, a, $urandom, scr);
   endtask

   task automatic run_random(input int i, input int n);
      for (int k = 0; k < n; k++) begin
         rand_op(i, 1'($urandom));
         if ($urandom_range(0, 7) == 0) begin
            quiesce(i);
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
      end
      quiesce(i);
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         mon_rdy = (cyc > busy_until[i]);
         chk($sformatf("req_ready[%0d]", i), {31'b0, ready_s[i]}, {31'b0, mon_rdy});
         if (valid_s[i]) begin
            if (q[i].size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_resp[%0d]: got resp_valid=1 expected none (cycle %0d)", i, cyc);
            end else begin
               mon_e = q[i].pop_front();
               chk($sformatf("latency[%0d]", i), 32'(cyc), mon_e.cyc);
               chk($sformatf("resp_err[%0d]", i), {31'b0, err_s[i]}, {31'b0, mon_e.err});
               if (mon_e.chk) chk($sformatf("mem_in[%0d]", i), mem_in_s[i], mon_e.data);
            end
         end else begin
            if (mon_rdy) begin
               chk($sformatf("idle_mem_in[%0d]", i), mem_in_s[i], 32'h0);
               chk($sformatf("idle_err[%0d]", i), {31'b0, err_s[i]}, 32'h0);
            end
            if (q[i].size() > 0 && cyc > int'(q[i][0].cyc)) begin
               mon_e = q[i].pop_front();
               checks++;
               errors++;
               $display("FAIL missing_resp[%0d]: got no resp_valid expected one at cycle %0d (now %0d)",
                        i, mon_e.cyc, cyc);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no completion expected finish within time limit");
      $fatal(1);
   end

   initial begin
      rst_s = 3'b111;
      for (int i = 0; i < 3; i++) begin
         ctrl_s[i] = 2'b00;
         f3_s[i]   = 3'b000;
         addr_s[i] = '0;
         data_s[i] = '0;
      end
      repeat (3) @(negedge clk);
      #1 rst_s = 3'b000;

      for (int i = 0; i < 3; i++) begin
         for (int k = 0; k < 16; k++) issue(i, 2'b10, 3'b010, 32'(4 * k), $urandom, 1'b0);
         issue(i, 2'b10, 3'b010, 32'hFFC, $urandom, 1'b0);
         quiesce(i);
      end

      // Zero wait states: byte/half/word stores and loads, then error cases.
      issue(0, 2'b10, 3'b010, 32'h8, 32'hDEADBEEF, 1'b0);
      issue(0, 2'b01, 3'b010, 32'h8, 32'h0, 1'b0);
      issue(0, 2'b10, 3'b000, 32'h9, 32'h80, 1'b0);
      issue(0, 2'b01, 3'b000, 32'h9, 32'h0, 1'b0);
      issue(0, 2'b01, 3'b100, 32'h9, 32'h0, 1'b0);
      issue(0, 2'b01, 3'b010, 32'h8, 32'h0, 1'b0);
      issue(0, 2'b10, 3'b001, 32'hA, 32'h1234, 1'b0);
      issue(0, 2'b01, 3'b001, 32'hA, 32'h0, 1'b0);
      issue(0, 2'b01, 3'b101, 32'h8, 32'h0, 1'b0);
      issue(0, 2'b01, 3'b010, 32'h6, 32'h0, 1'b0);
      issue(0, 2'b10, 3'b001, 32'h3, 32'hFFFF, 1'b0);
      issue(0, 2'b01, 3'b010, 32'(4 * DEPTH), 32'h0, 1'b0);
      issue(0, 2'b11, 3'b010, 32'h8, 32'h5555AAAA, 1'b0);
      issue(0, 2'b01, 3'b010, 32'h8, 32'h0, 1'b0);
      issue(0, 2'b01, 3'b010, 32'h0, 32'h0, 1'b0);
      quiesce(0);

      // Three wait states: reset mid-WAIT drops the pending store.
      @(negedge clk); #1;
      while (cyc <= busy_until[2]) begin
         @(negedge clk); #1;
      end
      ctrl_s[2] = 2'b10;
      f3_s[2]   = 3'b010;
      addr_s[2] = 32'h10;
      data_s[2] = 32'hCAFEF00D;
      busy_until[2] = cyc + 1 + wait_of(2);
      @(negedge clk);
      @(negedge clk);
      #2;
      rst_s[2] = 1'b1;
      busy_until[2] = -1;
      ctrl_s[2] = 2'b00;
      repeat (2) @(negedge clk);
      #2 rst_s[2] = 1'b0;
      issue(2, 2'b01, 3'b010, 32'h10, 32'h0, 1'b0);
      quiesce(2);

      // Two wait states: back-to-back requests left on the bus between accepts.
      for (int k = 0; k < 8; k++) begin
         if (k % 2 == 0) issue(1, 2'b10, 3'b010, 32'(4 * k), $urandom, 1'b0);
         else            issue(1, 2'b01, 3'b010, 32'(4 * (k - 1)), 32'h0, 1'b0);
      end
      quiesce(1);

      fork
         run_random(0, 300);
         run_random(1, 150);
         run_random(2, 150);
      join

      for (int k = 0; k < 50; k++) begin
         if (q[0].size() == 0 && q[1].size() == 0 && q[2].size() == 0) break;
         @(negedge clk);
      end
      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
